// File: rtl/stepper_phase_decoder.sv
// Receive-side decoder for a three-phase, six-beat stepper drive: synchronizes and
// debounces the phase lines, tracks direction and signed position, flags faults.
module stepper_phase_decoder #(
    parameter int POS_W = 8,
    parameter int FILT  = 2
) (
    input  logic                    CP,
    input  logic                    CR,
    input  logic [2:0]              Phase,
    output logic                    Step,
    output logic                    Dir,
    output logic signed [POS_W-1:0] Pos,
    output logic                    Locked,
    output logic                    Err,
    output logic [1:0]              ErrCode
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [3:0]              FILT_L  = 4'(FILT);
    localparam logic [3:0]              CNT_MAX = 4'd15;
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [2:0]              IDX_BAD = 3'd7;
    localparam logic [1:0]              EC_ILLEGAL = 2'b01;
    localparam logic [1:0]              EC_SKIP    = 2'b10;

    // Position of a code on the six-beat ring; IDX_BAD marks 000 and 111.
    function automatic logic [2:0] beat_index(input logic [2:0] code);
        logic [2:0] idx;
        case (code)
            3'b001:  idx = 3'd0;
            3'b011:  idx = 3'd1;
            3'b010:  idx = 3'd2;
            3'b110:  idx = 3'd3;
            3'b100:  idx = 3'd4;
            3'b101:  idx = 3'd5;
            default: idx = IDX_BAD;
        endcase
        return idx;
    endfunction

    // Forward distance (to - from) mod 6 for two legal ring indices.
    function automatic logic [2:0] ring_delta(input logic [2:0] from_idx,
                                              input logic [2:0] to_idx);
        logic [3:0] t;
        t = {1'b0, to_idx} + 4'd6 - {1'b0, from_idx};
        if (t >= 4'd6) begin
            t = t - 4'd6;
        end
        return t[2:0];
    endfunction

    logic [2:0]              s1_q, s2_q, acc_q;
    logic [3:0]              cnt_q, cnt_d;
    state_t                  state_q;
    logic                    step_q, dir_q, locked_q, err_q;
    logic signed [POS_W-1:0] pos_q;
    logic [1:0]              errcode_q;

    logic [2:0] s2_idx, acc_idx, delta;
    logic       legal, accept;

    // cnt_q counts consecutive edges on which s2 did not change, so a code is
    // taken once s2 has been stable for FILT edges beyond its own load edge.
    always_comb begin
        s2_idx  = beat_index(s2_q);
        acc_idx = beat_index(acc_q);
        legal   = (s2_idx != IDX_BAD);
        delta   = ring_delta(acc_idx, s2_idx);
        if (s1_q != s2_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
        accept = (cnt_q >= FILT_L) && (s2_q != acc_q);
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            s1_q      <= 3'b000;
            s2_q      <= 3'b000;
            acc_q     <= 3'b000;
            cnt_q     <= 4'd0;
            state_q   <= ST_INIT;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            pos_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= 2'b00;
        end else begin
            s1_q   <= Phase;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            step_q <= 1'b0;
            if (accept) begin
                acc_q <= s2_q;
                case (state_q)
                    ST_INIT: begin
                        if (legal) begin
                            state_q  <= ST_TRACK;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (!legal) begin
                            state_q  <= ST_FAULT;
                            locked_q <= 1'b0;
                            err_q    <= 1'b1;
                            if (!err_q) errcode_q <= EC_ILLEGAL;
                        end else if (delta == 3'd1) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b1;
                            pos_q  <= pos_q + POS_ONE;
                        end else if (delta == 3'd5) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b0;
                            pos_q  <= pos_q - POS_ONE;
                        end else begin
                            state_q  <= ST_FAULT;
                            locked_q <= 1'b0;
                            err_q    <= 1'b1;
                            if (!err_q) errcode_q <= EC_SKIP;
                        end
                    end
                    ST_FAULT: begin
                        // Err/ErrCode stay sticky; only tracking resumes.
                        if (legal) begin
                            state_q  <= ST_TRACK;
                            locked_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= ST_INIT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Step    = step_q;
    assign Dir     = dir_q;
    assign Pos     = pos_q;
    assign Locked  = locked_q;
    assign Err     = err_q;
    assign ErrCode = errcode_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: directed scenarios plus random phase traffic,
// all checked against a sample-history reference model.
module tb_stepper_phase_decoder;

    localparam int POS_W = 8;
    localparam int FILT  = 2;

    logic                    CP = 1'b0;
    logic                    CR = 1'b1;
    logic [2:0]              Phase = 3'b000;
    logic                    Step, Dir, Locked, Err;
    logic signed [POS_W-1:0] Pos;
    logic [1:0]              ErrCode;

    int n_checks = 0;
    int n_errors = 0;

    stepper_phase_decoder #(.POS_W(POS_W), .FILT(FILT)) dut (
        .CP(CP), .CR(CR), .Phase(Phase), .Step(Step), .Dir(Dir), .Pos(Pos),
        .Locked(Locked), .Err(Err), .ErrCode(ErrCode)
    );

    always #5 CP = ~CP;

    logic [2:0] ring [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    // Reference model state
    logic [2:0] hist[$];
    logic [2:0] m_acc;
    int         m_mode;          // 0 init, 1 track, 2 fault
    logic       m_step, m_dir, m_locked, m_err;
    logic [1:0] m_code;
    int         m_pos;
    int         m_steps_total;

    int mm, steps_seen, last_lat, dut_steps_total;
    logic [POS_W-1:0] epos, saved;

    function automatic int idx_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (ring[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (20) hist.push_back(3'b000);
        m_acc = 3'b000; m_mode = 0; m_step = 1'b0; m_dir = 1'b1; m_pos = 0;
        m_locked = 1'b0; m_err = 1'b0; m_code = 2'b00;
    endtask

    task automatic model_fault(input logic [1:0] c);
        m_mode = 2; m_locked = 1'b0;
        if (!m_err) m_code = c;
        m_err = 1'b1;
    endtask

    // A code is taken when the FILT+1 samples ending two edges ago all agree
    // and differ from the last taken code.
    task automatic model_edge(input logic [2:0] p);
        int L, ni, oi, d;
        logic [2:0] v;
        bit stable;
        m_step = 1'b0;
        hist.push_back(p);
        L = hist.size();
        v = hist[L-3];
        stable = 1;
        for (int k = 0; k <= FILT; k++) if (hist[L-3-k] != v) stable = 0;
        if (stable && v != m_acc) begin
            oi = idx_of(m_acc);
            ni = idx_of(v);
            m_acc = v;
            if (m_mode == 0) begin
                if (ni >= 0) begin m_mode = 1; m_locked = 1'b1; end
            end else if (m_mode == 1) begin
                if (ni < 0) model_fault(2'b01);
                else begin
                    d = (ni - oi + 6) % 6;
                    if (d == 1)      begin m_step = 1'b1; m_dir = 1'b1; m_pos++; m_steps_total++; end
                    else if (d == 5) begin m_step = 1'b1; m_dir = 1'b0; m_pos--; m_steps_total++; end
                    else model_fault(2'b10);
                end
            end else if (ni >= 0) begin
                m_mode = 1; m_locked = 1'b1;
            end
        end
        while (hist.size() > 40) void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge CP);
        model_edge(Phase);
        @(negedge CP);
    endtask

    // Drive a code for n cycles; gathers step counts and model disagreements.
    task automatic drive_hold(input logic [2:0] code, input int n);
        Phase = code;
        last_lat = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (Step === 1'b1) begin
                steps_seen++; dut_steps_total++;
                if (last_lat < 0) last_lat = i;
            end
            epos = m_pos[POS_W-1:0];
            if (Step !== m_step || Dir !== m_dir || Pos !== epos || Locked !== m_locked ||
                Err !== m_err || ErrCode !== m_code) mm++;
        end
    endtask

    task automatic do_reset();
        Phase = 3'b000;
        CR = 1'b1;
        @(negedge CP);
        @(negedge CP);
        CR = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge CP);
        @(negedge CP);
        n_checks++; if (Step !== 1'b0)   begin n_errors++; $display("FAIL reset_step: got %b want 0", Step); end
        n_checks++; if (Dir !== 1'b1)    begin n_errors++; $display("FAIL reset_dir: got %b want 1", Dir); end
        n_checks++; if (Pos !== 8'h00)   begin n_errors++; $display("FAIL reset_pos: got %h want 00", Pos); end
        n_checks++; if (Locked !== 1'b0 || Err !== 1'b0 || ErrCode !== 2'b00) begin
            n_errors++; $display("FAIL reset_flags: got L=%b E=%b C=%b want 0 0 00", Locked, Err, ErrCode);
        end
        CR = 1'b0;
        model_reset();
    endtask

    task automatic test_lock();
        int lock_edge;
        lock_edge = -1;
        mm = 0; steps_seen = 0;
        Phase = 3'b001;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Locked === 1'b1 && lock_edge < 0) lock_edge = i;
            if (Step !== 1'b0) steps_seen++;
        end
        n_checks++; if (lock_edge !== 2 + FILT) begin n_errors++; $display("FAIL lock_latency: got %0d want %0d", lock_edge, 2 + FILT); end
        n_checks++; if (steps_seen !== 0) begin n_errors++; $display("FAIL lock_nostep: got %0d steps want 0", steps_seen); end
        n_checks++; if (Pos !== 8'h00 || Locked !== m_locked) begin
            n_errors++; $display("FAIL lock_state: got pos=%h L=%b want 00 %b", Pos, Locked, m_locked);
        end
    endtask

    task automatic test_forward_sweep();
        mm = 0; steps_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            drive_hold(ring[i % 6], 12);
            n_checks++; if (last_lat !== 2 + FILT) begin n_errors++; $display("FAIL fwd_latency%0d: got %0d want %0d", i, last_lat, 2 + FILT); end
        end
        n_checks++; if (steps_seen !== 6) begin n_errors++; $display("FAIL fwd_steps: got %0d want 6", steps_seen); end
        n_checks++; if (Pos !== 8'h06 || Dir !== 1'b1) begin n_errors++; $display("FAIL fwd_pos: got pos=%h dir=%b want 06 1", Pos, Dir); end
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL fwd_model: got %0d bad cycles want 0", mm); end
    endtask

    task automatic test_reverse_wrap();
        int ci;
        mm = 0; steps_seen = 0;
        drive_hold(3'b101, 12);
        drive_hold(3'b100, 12);
        n_checks++; if (steps_seen !== 2 || Pos !== 8'h04 || Dir !== 1'b0) begin
            n_errors++; $display("FAIL rev_short: got steps=%0d pos=%h dir=%b want 2 04 0", steps_seen, Pos, Dir);
        end
        ci = 4;
        for (int b = 0; b < 132; b++) begin
            ci = (ci + 5) % 6;
            drive_hold(ring[ci], 4);
        end
        drive_hold(ring[ci], 6);
        n_checks++; if (Pos !== 8'h80) begin n_errors++; $display("FAIL rev_min: got %h want 80", Pos); end
        for (int b = 0; b < 2; b++) begin
            ci = (ci + 5) % 6;
            drive_hold(ring[ci], 8);
        end
        n_checks++; if (Pos !== 8'h7E) begin n_errors++; $display("FAIL rev_wrap: got %h want 7e", Pos); end
        n_checks++; if (Err !== 1'b0 || mm !== 0) begin n_errors++; $display("FAIL rev_model: got err=%b bad=%0d want 0 0", Err, mm); end
        drive_hold(3'b011, 12);
    endtask

    task automatic test_glitch();
        mm = 0; steps_seen = 0;
        saved = Pos;
        drive_hold(3'b111, 1);
        drive_hold(3'b011, 12);
        n_checks++; if (steps_seen !== 0 || Err !== 1'b0) begin n_errors++; $display("FAIL glitch_quiet: got steps=%0d err=%b want 0 0", steps_seen, Err); end
        n_checks++; if (Pos !== saved || mm !== 0) begin n_errors++; $display("FAIL glitch_pos: got %h bad=%0d want %h 0", Pos, mm, saved); end
    endtask

    task automatic test_skip_fault();
        mm = 0;
        drive_hold(3'b001, 12);
        saved = Pos;
        steps_seen = 0;
        drive_hold(3'b010, 12);
        n_checks++; if (Err !== 1'b1 || ErrCode !== 2'b10 || Locked !== 1'b0) begin
            n_errors++; $display("FAIL skip_flags: got E=%b C=%b L=%b want 1 10 0", Err, ErrCode, Locked);
        end
        n_checks++; if (Pos !== saved || steps_seen !== 0) begin n_errors++; $display("FAIL skip_pos: got %h steps=%0d want %h 0", Pos, steps_seen, saved); end
        drive_hold(3'b110, 12);
        n_checks++; if (Locked !== 1'b1 || Pos !== saved) begin n_errors++; $display("FAIL skip_relock: got L=%b pos=%h want 1 %h", Locked, Pos, saved); end
        drive_hold(3'b100, 12);
        saved = saved + 8'h01;
        n_checks++; if (steps_seen !== 1 || Pos !== saved || Err !== 1'b1) begin
            n_errors++; $display("FAIL skip_resume: got steps=%0d pos=%h err=%b want 1 %h 1", steps_seen, Pos, Err, saved);
        end
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL skip_model: got %0d bad cycles want 0", mm); end
    endtask

    task automatic test_illegal();
        do_reset();
        mm = 0;
        drive_hold(3'b001, 12);
        drive_hold(3'b111, 12);
        n_checks++; if (ErrCode !== 2'b01 || Err !== 1'b1 || Locked !== 1'b0) begin
            n_errors++; $display("FAIL illegal_flags: got C=%b E=%b L=%b want 01 1 0", ErrCode, Err, Locked);
        end
        drive_hold(3'b011, 12);
        n_checks++; if (Locked !== 1'b1) begin n_errors++; $display("FAIL illegal_relock: got %b want 1", Locked); end
        drive_hold(3'b110, 12);
        n_checks++; if (ErrCode !== 2'b01 || Locked !== 1'b0) begin n_errors++; $display("FAIL illegal_first: got C=%b L=%b want 01 0", ErrCode, Locked); end
        drive_hold(3'b010, 12);
        drive_hold(3'b011, 12);
        n_checks++; if (Pos !== 8'hFF || Dir !== 1'b0 || mm !== 0) begin
            n_errors++; $display("FAIL illegal_track: got pos=%h dir=%b bad=%0d want ff 0 0", Pos, Dir, mm);
        end
    endtask

    task automatic test_async_reset();
        #2 CR = 1'b1;
        #1;
        n_checks++; if (Pos !== 8'h00 || Dir !== 1'b1 || Step !== 1'b0) begin
            n_errors++; $display("FAIL async_data: got pos=%h dir=%b step=%b want 00 1 0", Pos, Dir, Step);
        end
        n_checks++; if (Locked !== 1'b0 || Err !== 1'b0 || ErrCode !== 2'b00) begin
            n_errors++; $display("FAIL async_flags: got L=%b E=%b C=%b want 0 0 00", Locked, Err, ErrCode);
        end
        Phase = 3'b000;
        @(negedge CP);
        CR = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [2:0] cur, nxt;
        int k, ci;
        mm = 0; m_steps_total = 0; dut_steps_total = 0;
        cur = 3'b000;
        for (int s = 0; s < 300; s++) begin
            k = $urandom_range(0, 9);
            ci = idx_of(cur);
            if (ci < 0) ci = $urandom_range(0, 5);
            case (k)
                0, 1, 2: nxt = ring[(ci + 1) % 6];
                3, 4, 5: nxt = ring[(ci + 5) % 6];
                6:       nxt = ring[(ci + 2 + $urandom_range(0, 2)) % 6];
                7:       nxt = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
                8: begin
                    drive_hold(3'($urandom_range(0, 7)), 1);
                    nxt = cur;
                end
                default: nxt = cur;
            endcase
            drive_hold(nxt, $urandom_range(1, 6));
            cur = nxt;
            if (s == 150) begin
                do_reset();
                cur = 3'b000;
            end
        end
        n_checks++; if (mm !== 0) begin n_errors++; $display("FAIL random_model: got %0d bad cycles want 0", mm); end
        n_checks++; if (dut_steps_total !== m_steps_total) begin
            n_errors++; $display("FAIL random_steps: got %0d want %0d", dut_steps_total, m_steps_total);
        end
    endtask

    initial begin
        model_reset();
        m_steps_total = 0; dut_steps_total = 0;
        test_reset();
        test_lock();
        test_forward_sweep();
        test_reverse_wrap();
        test_glitch();
        test_skip_fault();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
